// File: rtl/regfile.sv
// Architectural register file with per-register rename tags and commit bypass.
// Register 0 is hardwired to data 0 / tagFree; commits clear a tag only when the committing tag still owns it.
module regfile #(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned regWidth  = 5,
    parameter int unsigned tagWidth  = 4,
    parameter logic [tagWidth-1:0] tagFree = {1'b1, {(tagWidth-1){1'b0}}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 renameEnable,
    input  logic [regWidth-1:0]  renameReg,
    input  logic [tagWidth-1:0]  renameTag,
    input  logic [regWidth-1:0]  reg1Name,
    input  logic [regWidth-1:0]  reg2Name,
    output logic [dataWidth-1:0] reg1Data,
    output logic [dataWidth-1:0] reg2Data,
    output logic [tagWidth-1:0]  reg1Tag,
    output logic [tagWidth-1:0]  reg2Tag,
    input  logic                 regfileEnable,
    input  logic [regWidth-1:0]  rob_reg_name,
    input  logic [dataWidth-1:0] rob_reg_data,
    input  logic [tagWidth-1:0]  rob_reg_tag
);

    localparam int unsigned NumRegs = 1 << regWidth;

    logic [dataWidth-1:0] data_q [NumRegs];
    logic [dataWidth-1:0] data_d [NumRegs];
    logic [tagWidth-1:0]  tag_q  [NumRegs];
    logic [tagWidth-1:0]  tag_d  [NumRegs];

    logic commit_valid;
    logic rename_valid;

    assign commit_valid = regfileEnable && (rob_reg_name != '0);
    assign rename_valid = renameEnable && (renameReg != '0);

    // Rename is applied after the commit clear so it wins on the same register.
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        if (commit_valid) begin
            data_d[rob_reg_name] = rob_reg_data;
            if (tag_q[rob_reg_name] == rob_reg_tag) begin
                tag_d[rob_reg_name] = tagFree;
            end
        end
        if (rename_valid) begin
            tag_d[renameReg] = renameTag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= tagFree;
            end
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    // Read ports see pre-rename state; a matching commit is forwarded combinationally.
    always_comb begin
        reg1Data = data_q[reg1Name];
        reg1Tag  = tag_q[reg1Name];
        if (reg1Name == '0) begin
            reg1Data = '0;
            reg1Tag  = tagFree;
        end else if (regfileEnable && (rob_reg_name == reg1Name)
                     && (rob_reg_tag == tag_q[reg1Name])) begin
            reg1Data = rob_reg_data;
            reg1Tag  = tagFree;
        end
    end

    always_comb begin
        reg2Data = data_q[reg2Name];
        reg2Tag  = tag_q[reg2Name];
        if (reg2Name == '0) begin
            reg2Data = '0;
            reg2Tag  = tagFree;
        end else if (regfileEnable && (rob_reg_name == reg2Name)
                     && (rob_reg_tag == tag_q[reg2Name])) begin
            reg2Data = rob_reg_data;
            reg2Tag  = tagFree;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: stimulus pushes expected read-port values into a scoreboard,
// a monitor on the falling edge pops and compares them.
module tb_regfile;

    localparam logic [3:0] TFREE = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        renameEnable = 1'b0;
    logic [4:0]  renameReg = '0;
    logic [3:0]  renameTag = '0;
    logic [4:0]  reg1Name = '0;
    logic [4:0]  reg2Name = '0;
    logic [31:0] reg1Data;
    logic [31:0] reg2Data;
    logic [3:0]  reg1Tag;
    logic [3:0]  reg2Tag;
    logic        regfileEnable = 1'b0;
    logic [4:0]  rob_reg_name = '0;
    logic [31:0] rob_reg_data = '0;
    logic [3:0]  rob_reg_tag = '0;

    regfile #(
        .dataWidth(32),
        .regWidth (5),
        .tagWidth (4),
        .tagFree  (TFREE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .renameEnable (renameEnable),
        .renameReg    (renameReg),
        .renameTag    (renameTag),
        .reg1Name     (reg1Name),
        .reg2Name     (reg2Name),
        .reg1Data     (reg1Data),
        .reg2Data     (reg2Data),
        .reg1Tag      (reg1Tag),
        .reg2Tag      (reg2Tag),
        .regfileEnable(regfileEnable),
        .rob_reg_name (rob_reg_name),
        .rob_reg_data (rob_reg_data),
        .rob_reg_tag  (rob_reg_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port2;
        logic [31:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            string       nm;
            logic [31:0] ad;
            logic [3:0]  at;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            ad = e.port2 ? reg2Data : reg1Data;
            at = e.port2 ? reg2Tag  : reg1Tag;
            checks++;
            if (ad !== e.data || at !== e.tag) begin
                errors++;
                $display("FAIL %s port%0d: got data=%h tag=%h, expected data=%h tag=%h",
                         nm, e.port2 ? 2 : 1, ad, at, e.data, e.tag);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ren, input logic [4:0] rreg, input logic [3:0] rtag,
                         input logic cen, input logic [4:0] cname, input logic [31:0] cdata,
                         input logic [3:0] ctag, input logic [4:0] r1, input logic [4:0] r2);
        renameEnable  = ren;
        renameReg     = rreg;
        renameTag     = rtag;
        regfileEnable = cen;
        rob_reg_name  = cname;
        rob_reg_data  = cdata;
        rob_reg_tag   = ctag;
        reg1Name      = r1;
        reg2Name      = r2;
    endtask

    task automatic expect_rd(input string nm, input logic p2, input logic [31:0] d, input logic [3:0] t);
        exp_t e;
        e.port2 = p2;
        e.data  = d;
        e.tag   = t;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        // Held in reset: read x5 and x0
        drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        expect_rd("rst_x5", 0, 32'h0, TFREE);
        expect_rd("rst_x0", 1, 32'h0, TFREE);
        tick();
        tick();
        rst = 1'b1;
        expect_rd("post_rst_x5", 0, 32'h0, TFREE);

        // Rename x3 -> tag 2; same-cycle read sees pre-rename mapping
        tick();
        drive(1, 5'd3, 4'd2, 0, 0, 0, 0, 5'd3, 5'd0);
        expect_rd("x3_prerename", 0, 32'h0, TFREE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        expect_rd("x3_renamed", 0, 32'h0, 4'd2);
        // Commit with matching tag: bypass on both ports
        tick();
        drive(0, 0, 0, 1, 5'd3, 32'hDEADBEEF, 4'd2, 5'd3, 5'd3);
        expect_rd("x3_bypass1", 0, 32'hDEADBEEF, TFREE);
        expect_rd("x3_bypass2", 1, 32'hDEADBEEF, TFREE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        expect_rd("x3_stored", 0, 32'hDEADBEEF, TFREE);

        // x4: tag 1 then tag 5; older commit writes data but leaves tag 5
        tick();
        drive(1, 5'd4, 4'd1, 0, 0, 0, 0, 5'd0, 5'd4);
        tick();
        drive(1, 5'd4, 4'd5, 0, 0, 0, 0, 5'd0, 5'd4);
        expect_rd("x4_tag1", 1, 32'h0, 4'd1);
        tick();
        drive(0, 0, 0, 1, 5'd4, 32'd7, 4'd1, 5'd0, 5'd4);
        expect_rd("x4_nobypass", 1, 32'h0, 4'd5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd4);
        expect_rd("x4_stored", 1, 32'd7, 4'd5);

        // x6: same-cycle rename tag 3 and commit tag 3
        tick();
        drive(1, 5'd6, 4'd3, 1, 5'd6, 32'd9, 4'd3, 5'd6, 5'd0);
        expect_rd("x6_prerename", 0, 32'h0, TFREE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd0);
        expect_rd("x6_after", 0, 32'd9, 4'd3);

        // x7: commit clears matching tag but same-cycle rename must win
        tick();
        drive(1, 5'd7, 4'd2, 0, 0, 0, 0, 5'd0, 5'd0);
        tick();
        drive(1, 5'd7, 4'd6, 1, 5'd7, 32'h11, 4'd2, 5'd0, 5'd7);
        expect_rd("x7_bypass", 1, 32'h11, TFREE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd7);
        expect_rd("x7_rename_wins", 1, 32'h11, 4'd6);

        // x0 ignores rename and commit (commit tag equals tagFree)
        tick();
        drive(1, 5'd0, 4'd3, 1, 5'd0, 32'h55, TFREE, 5'd0, 5'd0);
        expect_rd("x0_same1", 0, 32'h0, TFREE);
        expect_rd("x0_same2", 1, 32'h0, TFREE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        expect_rd("x0_after1", 0, 32'h0, TFREE);
        expect_rd("x0_after2", 1, 32'h0, TFREE);

        // Several renames, then asynchronous reset between edges
        tick();
        drive(1, 5'd8, 4'd1, 0, 0, 0, 0, 5'd0, 5'd0);
        tick();
        drive(1, 5'd9, 4'd2, 0, 0, 0, 0, 5'd8, 5'd0);
        expect_rd("x8_tag", 0, 32'h0, 4'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd8);
        #3;
        rst = 1'b0;
        expect_rd("async_x3", 0, 32'h0, TFREE);
        expect_rd("async_x8", 1, 32'h0, TFREE);
        // Updates presented during reset are discarded; non-matching commit does not bypass
        tick();
        drive(1, 5'd9, 4'd5, 1, 5'd4, 32'h77, 4'd5, 5'd9, 5'd4);
        expect_rd("rst_x9", 0, 32'h0, TFREE);
        expect_rd("rst_x4", 1, 32'h0, TFREE);
        tick();
        rst = 1'b1;
        drive(1, 5'd9, 4'd5, 0, 0, 0, 0, 5'd9, 5'd4);
        expect_rd("rel_x9", 0, 32'h0, TFREE);
        expect_rd("rel_x4", 1, 32'h0, TFREE);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
        expect_rd("rel_x9_next", 0, 32'h0, 4'd5);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
